// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg
//   Shared types for the instruction-fetch adapter:
//   - t_fetch_state  : fetch FSM encoding
//   - t_fetch_buffer : one-word fetch buffer {valid, tag, data}
//   - join_halfwords : builds a 32-bit instruction from two halfwords
package riscv_fetch_pkg;

    // Widest word tag a 32-bit byte address can produce (bits [31:2]).
    localparam int FETCH_TAG_WIDTH = 30;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,  // waiting for a request
        ISSUE_HI = 2'd1,  // second SRAM read of a misaligned miss
        WAIT     = 2'd2,  // counting down SRAM latency
        RESP     = 2'd3   // response strobe cycle
    } t_fetch_state;

    // The tag is stored zero-extended to the widest possible word address so
    // the struct does not depend on the SRAM size parameter.
    typedef struct packed {
        logic                       valid;
        logic [FETCH_TAG_WIDTH-1:0] tag;
        logic [31:0]                data;
    } t_fetch_buffer;

    function automatic logic [31:0] join_halfwords(input logic [15:0] upper,
                                                   input logic [15:0] lower);
        return {upper, lower};
    endfunction

endpackage

// File: rtl/riscv_fetch_word_buffer.sv
// riscv_fetch_word_buffer
//   One-word fetch buffer used to skip the lower read of a misaligned fetch
//   that continues from the previously fetched word.
//   Ports:
//     clk, reset_n     clock, asynchronous active-low reset
//     flush            invalidate at the next edge; wins over a fill
//     fill_en          write {fill_tag, fill_data} this cycle
//     fill_tag/data    word being written
//     lookup_tag       word address to compare against
//     hit              lookup matches (bypassing a same-cycle fill)
//     hit_upper        bits [31:16] of the matching word
module riscv_fetch_word_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int TAG_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 fill_en,
    input  logic [TAG_WIDTH-1:0] fill_tag,
    input  logic [31:0]          fill_data,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    output logic                 hit,
    output logic [15:0]          hit_upper
);

    t_fetch_buffer buf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
        end else if (fill_en) begin
            buf_q.tag   <= FETCH_TAG_WIDTH'(fill_tag);
            buf_q.data  <= fill_data;
            buf_q.valid <= ~flush;
        end else if (flush) begin
            buf_q.valid <= 1'b0;
        end
    end

    // While a fill is in progress the buffer will hold the fill word after
    // this edge, so a request accepted now compares against that word.
    // A flush in the lookup cycle always forces a miss.
    always_comb begin
        hit       = 1'b0;
        hit_upper = buf_q.data[31:16];
        if (fill_en) begin
            hit       = ~flush && (fill_tag == lookup_tag);
            hit_upper = fill_data[31:16];
        end else begin
            hit = ~flush && buf_q.valid &&
                  (buf_q.tag == FETCH_TAG_WIDTH'(lookup_tag));
        end
    end

endmodule

// File: rtl/riscv_imem_fetch_adapter.sv
// riscv_imem_fetch_adapter
//   Returns 32-bit instruction words from any halfword-aligned address using
//   a single-port 32-bit SRAM with SRAM_LATENCY (1..3) read latency.
//   Ports:
//     clk, reset_n     clock, asynchronous active-low reset
//     req_valid/ready  request handshake; accepted when both are high
//     req_address      byte address (bit 0 must be 0)
//     resp_valid       one-cycle response strobe
//     resp_data        instruction word, valid with resp_valid
//     flush            invalidate the fetch buffer
//     sram_select      SRAM read strobe
//     sram_address     SRAM word address
//     sram_read_data   SRAM data, SRAM_LATENCY cycles after select
//   Handshake: a request transfers on a cycle where req_valid and req_ready
//   are both high; req_ready is high in IDLE and RESP, so a new request can
//   be accepted in the same cycle its predecessor responds. resp_valid has
//   no back-pressure.
module riscv_imem_fetch_adapter
    import riscv_fetch_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 14,
    parameter int SRAM_LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    input  logic [31:0]                req_address,
    output logic                       req_ready,
    output logic                       resp_valid,
    output logic [31:0]                resp_data,
    input  logic                       flush,
    output logic                       sram_select,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_address,
    input  logic [31:0]                sram_read_data
);

    localparam int          AW  = SRAM_ADDR_WIDTH;
    localparam logic [2:0]  LAT = 3'(SRAM_LATENCY);

    t_fetch_state state, state_next, first_state;

    logic [2:0]    cycle_cnt;    // cycles since acceptance
    logic          miss_r;       // transaction is a misaligned miss
    logic          aligned_r;    // transaction is aligned
    logic [AW-1:0] tag_r;        // word filled into the buffer; upper read of a miss
    logic [15:0]   hold_q;       // lower halfword of a misaligned response

    logic          accept;
    logic          misaligned;
    logic [AW-1:0] word_addr;
    logic [AW-1:0] word_addr_inc;
    logic          buf_hit;
    logic [15:0]   buf_upper;
    logic          accept_hit;
    logic          accept_miss;
    logic [2:0]    resp_cycle;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_address[31:AW+2];

    assign req_ready     = (state == IDLE) || (state == RESP);
    assign accept        = req_valid && req_ready;
    // Bit 0 is ignored; only bit 1 distinguishes halfword alignment.
    assign misaligned    = req_address[1];
    assign word_addr     = req_address[AW+1:2];
    assign word_addr_inc = word_addr + AW'(1);
    assign accept_hit    = accept && misaligned && buf_hit;
    assign accept_miss   = accept && misaligned && !buf_hit;
    assign resp_cycle    = miss_r ? (LAT + 3'd1) : LAT;

    riscv_fetch_word_buffer #(
        .TAG_WIDTH (AW)
    ) u_word_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .fill_en    (state == RESP),
        .fill_tag   (tag_r),
        .fill_data  (sram_read_data),
        .lookup_tag (word_addr),
        .hit        (buf_hit),
        .hit_upper  (buf_upper)
    );

    always_comb begin
        first_state = RESP;
        if (accept_miss)       first_state = ISSUE_HI;
        else if (LAT != 3'd1)  first_state = WAIT;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:           if (accept) state_next = first_state;
            ISSUE_HI, WAIT: state_next = ((cycle_cnt + 3'd1) == resp_cycle) ? RESP : WAIT;
            RESP:           state_next = accept ? first_state : IDLE;
            default:        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cycle_cnt <= 3'd0;
            miss_r    <= 1'b0;
            aligned_r <= 1'b0;
            tag_r     <= '0;
            hold_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cycle_cnt <= 3'd1;
                miss_r    <= accept_miss;
                aligned_r <= ~misaligned;
                tag_r     <= misaligned ? word_addr_inc : word_addr;
                if (accept_hit) hold_q <= buf_upper;
            end else if (state == ISSUE_HI || state == WAIT) begin
                cycle_cnt <= cycle_cnt + 3'd1;
                // Lower word of a miss arrives SRAM_LATENCY cycles after acceptance.
                if (miss_r && cycle_cnt == LAT) hold_q <= sram_read_data[31:16];
            end
        end
    end

    assign sram_select  = accept || (state == ISSUE_HI);
    assign sram_address = accept ? (accept_hit ? word_addr_inc : word_addr) : tag_r;

    assign resp_valid = (state == RESP);
    assign resp_data  = aligned_r ? sram_read_data
                                  : join_halfwords(sram_read_data[15:0], hold_q);

    a_addr_halfword: assert property (@(posedge clk) disable iff (!reset_n)
        (req_valid && req_ready) |-> !req_address[0]);

endmodule

// File: tb/tb_riscv_imem_fetch_adapter.sv
// tb_riscv_imem_fetch_adapter
//   Directed bench: instance a uses SRAM_LATENCY=1, instance b SRAM_LATENCY=3.
//   Each instance has its own SRAM model with the matching latency.
module tb_riscv_imem_fetch_adapter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush_a, flush_b;
    logic        a_valid, b_valid;
    logic [31:0] a_addr, b_addr;
    logic        a_ready, b_ready;
    logic        a_resp, b_resp;
    logic [31:0] a_data, b_data;
    logic        a_sel, b_sel;
    logic [13:0] a_sa, b_sa;
    logic [31:0] a_rd, b_rd;

    logic [31:0] mem_a [0:16383];
    logic [31:0] mem_b [0:16383];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_imem_fetch_adapter #(.SRAM_ADDR_WIDTH(14), .SRAM_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_address(a_addr),
        .req_ready(a_ready), .resp_valid(a_resp), .resp_data(a_data), .flush(flush_a),
        .sram_select(a_sel), .sram_address(a_sa), .sram_read_data(a_rd)
    );

    riscv_imem_fetch_adapter #(.SRAM_ADDR_WIDTH(14), .SRAM_LATENCY(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_address(b_addr),
        .req_ready(b_ready), .resp_valid(b_resp), .resp_data(b_data), .flush(flush_b),
        .sram_select(b_sel), .sram_address(b_sa), .sram_read_data(b_rd)
    );

    // SRAM models: data for a select appears LATENCY cycles later, 0 otherwise.
    logic        a_v_q;
    logic [13:0] a_a_q;
    always @(posedge clk) begin
        a_v_q <= a_sel;
        a_a_q <= a_sa;
    end
    assign a_rd = a_v_q ? mem_a[a_a_q] : 32'h0;

    logic [2:0]  b_v_q;
    logic [13:0] b_a_q [0:2];
    always @(posedge clk) begin
        b_v_q     <= {b_v_q[1:0], b_sel};
        b_a_q[0]  <= b_sa;
        b_a_q[1]  <= b_a_q[0];
        b_a_q[2]  <= b_a_q[1];
    end
    assign b_rd = b_v_q[2] ? mem_b[b_a_q[2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_addr  = 32'h0; b_addr = 32'h0;
        for (int i = 0; i < 16384; i++) begin
            mem_a[i] = 32'(i) ^ 32'h5A5A_0000;
            mem_b[i] = 32'(i) ^ 32'h5A5A_0000;
        end
        mem_a[14'h0040] = 32'h1122_3344; mem_b[14'h0040] = 32'h1122_3344;
        mem_a[14'h0041] = 32'hAABB_CCDD; mem_b[14'h0041] = 32'hAABB_CCDD;
        mem_a[14'h0042] = 32'h5566_7788; mem_b[14'h0042] = 32'h5566_7788;
        mem_a[14'h0043] = 32'h0F0E_0D0C;
        mem_a[14'h3FFF] = 32'hCAFE_F00D;
        mem_a[14'h0000] = 32'h0BAD_BEEF;
        mem_a[14'h0001] = 32'h1357_9BDF;

        // Reset state
        repeat (2) @(posedge clk);
        settle();
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_a_resp",  32'(a_resp),  32'd0);
        chk("rst_a_sel",   32'(a_sel),   32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_b_resp",  32'(b_resp),  32'd0);
        chk("rst_b_sel",   32'(b_sel),   32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Misaligned cold fetch 0x102, then sequential hit 0x106 in RESP
        a_valid = 1'b1; a_addr = 32'h0000_0102;
        settle();
        chk("cold_c0_sel",   32'(a_sel),   32'd1);
        chk("cold_c0_addr",  32'(a_sa),    32'h40);
        chk("cold_c0_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        settle();
        chk("cold_c1_sel",   32'(a_sel),   32'd1);
        chk("cold_c1_addr",  32'(a_sa),    32'h41);
        chk("cold_c1_ready", 32'(a_ready), 32'd0);
        chk("cold_c1_resp",  32'(a_resp),  32'd0);
        tick();
        a_valid = 1'b1; a_addr = 32'h0000_0106;
        settle();
        chk("cold_c2_resp",  32'(a_resp),  32'd1);
        chk("cold_c2_data",  a_data,       32'hCCDD_1122);
        chk("seq_c0_sel",    32'(a_sel),   32'd1);
        chk("seq_c0_addr",   32'(a_sa),    32'h42);
        tick();
        a_valid = 1'b0;
        settle();
        chk("seq_c1_resp",   32'(a_resp),  32'd1);
        chk("seq_c1_data",   a_data,       32'h7788_AABB);
        chk("seq_c1_sel",    32'(a_sel),   32'd0);
        tick();
        settle();
        chk("seq_c2_resp",   32'(a_resp),  32'd0);
        tick();

        // Aligned fetch 0x100
        a_valid = 1'b1; a_addr = 32'h0000_0100;
        settle();
        chk("al_c0_addr",    32'(a_sa),    32'h40);
        tick();
        a_valid = 1'b0;
        settle();
        chk("al_c1_resp",    32'(a_resp),  32'd1);
        chk("al_c1_data",    a_data,       32'h1122_3344);
        tick();

        // Flush, then 0x102 must miss despite the buffer holding word 0x40
        flush_a = 1'b1;
        settle();
        tick();
        flush_a = 1'b0;
        a_valid = 1'b1; a_addr = 32'h0000_0102;
        settle();
        chk("fl_c0_addr",    32'(a_sa),    32'h40);
        tick();
        a_valid = 1'b0;
        settle();
        chk("fl_c1_sel",     32'(a_sel),   32'd1);
        chk("fl_c1_addr",    32'(a_sa),    32'h41);
        tick();
        settle();
        chk("fl_c2_data",    a_data,       32'hCCDD_1122);
        tick();

        // Hit from IDLE (stored buffer, no bypass)
        a_valid = 1'b1; a_addr = 32'h0000_0106;
        settle();
        chk("hit_c0_addr",   32'(a_sa),    32'h42);
        tick();
        a_valid = 1'b0;
        settle();
        chk("hit_c1_resp",   32'(a_resp),  32'd1);
        chk("hit_c1_data",   a_data,       32'h7788_AABB);
        chk("hit_c1_sel",    32'(a_sel),   32'd0);
        tick();

        // Flush in the hit-check cycle forces a miss
        a_valid = 1'b1; a_addr = 32'h0000_010A; flush_a = 1'b1;
        settle();
        chk("flhit_c0_addr", 32'(a_sa),    32'h42);
        tick();
        a_valid = 1'b0; flush_a = 1'b0;
        settle();
        chk("flhit_c1_addr", 32'(a_sa),    32'h43);
        tick();
        settle();
        chk("flhit_c2_data", a_data,       32'h0D0C_5566);
        tick();

        // Wrap: 0xFFFE reads 0x3FFF then 0x0000; flush during the fill
        a_valid = 1'b1; a_addr = 32'h0000_FFFE;
        settle();
        chk("wrap_c0_addr",  32'(a_sa),    32'h3FFF);
        tick();
        a_valid = 1'b0;
        settle();
        chk("wrap_c1_addr",  32'(a_sa),    32'h0000);
        tick();
        flush_a = 1'b1;
        settle();
        chk("wrap_c2_resp",  32'(a_resp),  32'd1);
        chk("wrap_c2_data",  a_data,       32'hBEEF_CAFE);
        tick();
        flush_a = 1'b0;
        // Buffer was left invalid, so word 0 misses
        a_valid = 1'b1; a_addr = 32'h0000_0002;
        settle();
        chk("fw_c0_addr",    32'(a_sa),    32'h0000);
        tick();
        a_valid = 1'b0;
        settle();
        chk("fw_c1_sel",     32'(a_sel),   32'd1);
        chk("fw_c1_addr",    32'(a_sa),    32'h0001);
        tick();
        settle();
        chk("fw_c2_data",    a_data,       32'h9BDF_0BAD);
        tick();

        // Latency 3: misaligned miss then back-to-back hit
        b_valid = 1'b1; b_addr = 32'h0000_0102;
        settle();
        chk("l3_c0_addr",    32'(b_sa),    32'h40);
        tick();
        b_valid = 1'b0;
        settle();
        chk("l3_c1_addr",    32'(b_sa),    32'h41);
        chk("l3_c1_ready",   32'(b_ready), 32'd0);
        tick();
        settle();
        chk("l3_c2_ready",   32'(b_ready), 32'd0);
        chk("l3_c2_sel",     32'(b_sel),   32'd0);
        tick();
        settle();
        chk("l3_c3_ready",   32'(b_ready), 32'd0);
        chk("l3_c3_resp",    32'(b_resp),  32'd0);
        tick();
        b_valid = 1'b1; b_addr = 32'h0000_0106;
        settle();
        chk("l3_c4_resp",    32'(b_resp),  32'd1);
        chk("l3_c4_data",    b_data,       32'hCCDD_1122);
        chk("l3_hit_addr",   32'(b_sa),    32'h42);
        tick();
        b_valid = 1'b0;
        settle();
        chk("l3_h1_resp",    32'(b_resp),  32'd0);
        chk("l3_h1_ready",   32'(b_ready), 32'd0);
        tick();
        tick();
        settle();
        chk("l3_h3_resp",    32'(b_resp),  32'd1);
        chk("l3_h3_data",    b_data,       32'h7788_AABB);
        tick();
        settle();
        chk("l3_h4_resp",    32'(b_resp),  32'd0);
        tick();

        // Reset mid-transaction on instance a
        a_valid = 1'b1; a_addr = 32'h0000_0104;
        settle();
        tick();
        a_valid = 1'b0;
        settle();
        chk("pre_rst_data",  a_data,       32'hAABB_CCDD);
        tick();
        a_valid = 1'b1; a_addr = 32'h0000_010A;
        settle();
        chk("mr_c0_addr",    32'(a_sa),    32'h42);
        tick();
        a_valid = 1'b0;
        reset_n = 1'b0;
        settle();
        chk("mr_resp",       32'(a_resp),  32'd0);
        chk("mr_sel",        32'(a_sel),   32'd0);
        chk("mr_ready",      32'(a_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        tick();
        a_valid = 1'b1; a_addr = 32'h0000_0106;
        settle();
        chk("mr_next_addr",  32'(a_sa),    32'h41);
        tick();
        a_valid = 1'b0;
        settle();
        chk("mr_next_c1",    32'(a_sa),    32'h42);
        tick();
        settle();
        chk("mr_next_data",  a_data,       32'h7788_AABB);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_imem_fetch_adapter.md
# riscv_imem_fetch_adapter

Parametrised instruction-fetch adapter between a RISC-V core's instruction port and a single-port 32-bit synchronous SRAM with configurable read latency. It returns 32-bit instruction words from any halfword-aligned address, as needed for i32c. Misaligned fetches that straddle two words take two pipelined SRAM reads. A one-word fetch buffer removes the first of those reads on sequential compressed fetches, so no clock divider is required.

## Interface
Parameters:
- SRAM_ADDR_WIDTH, 14: SRAM word-address bits. Byte address bits [SRAM_ADDR_WIDTH+1:2] are used; higher bits are ignored.
- SRAM_LATENCY, 1: cycles from `sram_select` to valid `sram_read_data`. Legal range 1..3.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  fetch request
- req_address  input  32  byte address; bit 0 must be 0
- req_ready  output  1  request accepted when req_valid & req_ready
- resp_valid  output  1  one-cycle response strobe
- resp_data  output  32  instruction word; valid only with resp_valid
- flush  input  1  invalidate fetch buffer (fence.i, imem write)
- sram_select  output  1  SRAM read strobe
- sram_address  output  SRAM_ADDR_WIDTH  SRAM word address
- sram_read_data  input  32  SRAM data, SRAM_LATENCY cycles after select

## Operation
- One request outstanding at a time. W = req_address[SRAM_ADDR_WIDTH+1:2]. W+1 wraps modulo 2^SRAM_ADDR_WIDTH.
- Aligned request (bit 1 = 0):
  - Read W. resp_data = word(W).
  - Buffer <= {W, word(W)}, valid.
- Misaligned request, buffer miss:
  - Read W, then W+1 in the next cycle.
  - word(W)[31:16] is captured into a hold register.
  - resp_data = {word(W+1)[15:0], word(W)[31:16]}.
  - Buffer <= {W+1, word(W+1)}.
- Misaligned request, buffer hit (buffer valid and tag == W):
  - Read only W+1.
  - resp_data = {word(W+1)[15:0], buf_data[31:16]}.
  - Buffer <= {W+1, word(W+1)}.
- Aligned requests never use the buffer for data.
- State machine:
  - IDLE: accept a request.
  - ISSUE_HI: second read of a misaligned miss.
  - WAIT: count SRAM_LATENCY down.
  - RESP: resp_valid high.
  - Transitions: RESP goes to IDLE, or straight into a new transaction if a request is accepted in that cycle.
- req_ready = (state == IDLE) | (state == RESP).
- Back-to-back requests: a request accepted in the RESP cycle performs its hit check against the word being written to the buffer that cycle (bypass), not the stale buffer contents.
- flush:
  - Clears buffer valid at the next edge.
  - If flush coincides with a buffer fill, flush wins: the response is still delivered and the buffer is left invalid.
  - A flush in the same cycle as a hit check forces a miss.
  - A transaction in flight is never aborted.
- req_address bit 0 set is illegal (assertion); the adapter treats it as 0.

## Timing
Cycle 0 is the acceptance cycle. sram_select and sram_address are combinational from the accepted request in cycle 0.
- Aligned, or misaligned hit: resp_valid in cycle SRAM_LATENCY. resp_data passes combinationally from sram_read_data.
- Misaligned miss: selects in cycles 0 and 1; resp_valid in cycle SRAM_LATENCY+1.
- Throughput with back-to-back requests: one aligned or hit fetch every SRAM_LATENCY cycles.
- Reset values (asynchronous):
  - state IDLE, so req_ready = 1.
  - resp_valid 0, sram_select 0.
  - buffer valid 0; buffer tag/data and hold register 0.
  - When deasserted mid-transaction, no response is produced.
- resp_valid is never asserted for more than one cycle per accepted request.

## Structure
- Package riscv_fetch_pkg holds:
  - the state enum t_fetch_state (IDLE, ISSUE_HI, WAIT, RESP);
  - the struct t_fetch_buffer {valid, tag, data};
  - the helper that combines two halfwords.
- Sub-module riscv_fetch_word_buffer holds the tag/data/valid register. It performs the hit compare with bypass from the fill port and applies flush priority.
- The top level contains the FSM, the latency counter, the hold register, SRAM address generation and the response mux.

## Test plan
All scenarios use SRAM_LATENCY = 1 unless stated.
- Aligned fetch: mem[0x40] = 0x11223344, request 0x100 -> select at address 0x40 in cycle 0; resp_valid in cycle 1 with resp_data 0x11223344.
- Misaligned cold fetch: mem[0x40] = 0x11223344, mem[0x41] = 0xAABBCCDD, request 0x102 -> selects at 0x40 then 0x41; resp in cycle 2 with resp_data 0xCCDD1122.
- Sequential hit: request 0x106 accepted in the RESP cycle of the previous fetch, mem[0x42] = 0x55667788 -> a single select at 0x42; resp_data 0x7788AABB one cycle later.
- Flush and wrap: flush between the previous two fetches -> two reads occur. Separately, request 0xFFFE with SRAM_ADDR_WIDTH = 14 -> reads 0x3FFF then 0x0000.
- Latency sweep: SRAM_LATENCY = 3, misaligned miss -> resp_valid in cycle 4 with the correct combined data; req_ready stays low in cycles 1..3.
- Reset mid-transaction: assert reset_n low in cycle 1 of a misaligned miss -> resp_valid and sram_select are 0 immediately; req_ready = 1; the next fetch misses the buffer.
